// File: rtl/gen_elastic_pipe.sv
// Elastic register pipeline: DP stages of DW-bit data with per-stage valids,
// valid/ready on both ends, bubble collapse, synchronous flush and occupancy count.
module gen_elastic_pipe #(
  parameter int              DP      = 2,
  parameter int              DW      = 32,
  parameter logic [DW-1:0]   RST_VAL = {DW{1'b0}},
  parameter int              CW      = $clog2(DP + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] din,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] dout,
  output logic [CW-1:0] count
);

  if (DP < 1 || DP > 16) begin : g_bad_dp
    $error("gen_elastic_pipe: DP must be in 1..16");
  end
  if (DW < 1) begin : g_bad_dw
    $error("gen_elastic_pipe: DW must be at least 1");
  end
  if (CW != $clog2(DP + 1)) begin : g_bad_cw
    $error("gen_elastic_pipe: CW is derived from DP and must not be overridden");
  end

  logic [DP-1:0] v_q, v_d;
  logic [DW-1:0] d_q [DP];
  logic [DW-1:0] d_d [DP];
  logic [DP:0]   rdy;
  logic [DP-1:0] v_in;
  logic [DW-1:0] d_in [DP];
  logic [CW-1:0] cnt_q, cnt_d;

  // A stage may take new data when it is empty or the stage ahead of it moves.
  always_comb begin
    rdy     = '0;
    rdy[DP] = out_ready;
    for (int k = DP - 1; k >= 0; k--) begin
      rdy[k] = ~v_q[k] | rdy[k+1];
    end
  end

  always_comb begin
    v_in    = '0;
    v_in[0] = in_valid;
    d_in[0] = din;
    for (int k = 1; k < DP; k++) begin
      v_in[k] = v_q[k-1];
      d_in[k] = d_q[k-1];
    end
  end

  always_comb begin
    v_d   = v_q;
    d_d   = d_q;
    cnt_d = '0;
    if (flush) begin
      v_d = '0;
    end else begin
      for (int k = 0; k < DP; k++) begin
        if (rdy[k]) begin
          v_d[k] = v_in[k];
          // Data only moves with a real beat, so bubbles never overwrite d.
          if (v_in[k]) d_d[k] = d_in[k];
        end
      end
    end
    for (int k = 0; k < DP; k++) begin
      cnt_d = cnt_d + CW'(v_d[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      cnt_q <= '0;
      for (int k = 0; k < DP; k++) begin
        d_q[k] <= RST_VAL;
      end
    end else begin
      v_q   <= v_d;
      cnt_q <= cnt_d;
      d_q   <= d_d;
    end
  end

  assign in_ready  = rdy[0] & ~flush;
  assign out_valid = v_q[DP-1] & ~flush;
  assign dout      = d_q[DP-1];
  assign count     = cnt_q;

endmodule

// File: tb/tb_gen_elastic_pipe.sv
// Bench for gen_elastic_pipe: six instances (DP 2,3,4,1,5,16) share one stimulus
// stream; a queue-of-beats model predicts handshake, data, and occupancy.
module tb_gen_elastic_pipe;
  localparam int NI = 6;

  int          dpv  [NI] = '{2, 3, 4, 1, 5, 16};
  logic [31:0] rstv [NI] = '{32'h0, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0};

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] din;
  logic        irdy [NI];
  logic        ovld [NI];
  logic [31:0] dq   [NI];
  logic [1:0]  c0;
  logic [1:0]  c1;
  logic [2:0]  c2;
  logic [0:0]  c3;
  logic [2:0]  c4;
  logic [4:0]  c5;
  int          cnt  [NI];

  assign cnt[0] = int'(c0);
  assign cnt[1] = int'(c1);
  assign cnt[2] = int'(c2);
  assign cnt[3] = int'(c3);
  assign cnt[4] = int'(c4);
  assign cnt[5] = int'(c5);

  always #5 clk = ~clk;

  gen_elastic_pipe #(.DP(2), .DW(32)) u_dp2 (.clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(irdy[0]), .din(din), .out_valid(ovld[0]),
    .out_ready(out_ready), .dout(dq[0]), .count(c0));
  gen_elastic_pipe #(.DP(3), .DW(32)) u_dp3 (.clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(irdy[1]), .din(din), .out_valid(ovld[1]),
    .out_ready(out_ready), .dout(dq[1]), .count(c1));
  gen_elastic_pipe #(.DP(4), .DW(32), .RST_VAL(32'hDEADBEEF)) u_dp4 (.clk(clk), .rst(rst),
    .flush(flush), .in_valid(in_valid), .in_ready(irdy[2]), .din(din), .out_valid(ovld[2]),
    .out_ready(out_ready), .dout(dq[2]), .count(c2));
  gen_elastic_pipe #(.DP(1), .DW(32)) u_dp1 (.clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(irdy[3]), .din(din), .out_valid(ovld[3]),
    .out_ready(out_ready), .dout(dq[3]), .count(c3));
  gen_elastic_pipe #(.DP(5), .DW(32)) u_dp5 (.clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(irdy[4]), .din(din), .out_valid(ovld[4]),
    .out_ready(out_ready), .dout(dq[4]), .count(c4));
  gen_elastic_pipe #(.DP(16), .DW(32)) u_dp16 (.clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(irdy[5]), .din(din), .out_valid(ovld[5]),
    .out_ready(out_ready), .dout(dq[5]), .count(c5));

  // A beat accepted in cycle t is presentable once the cycle number reaches t+DP;
  // beats in flight compress toward the tail, so only the oldest one matters.
  typedef struct packed {
    logic [31:0] d;
    int          t;
  } beat_t;

  beat_t mq [NI][$];
  int    cyc    = 0;
  int    errors = 0;
  int    checks = 0;

  function automatic bit m_ready(int i);
    return !flush && (mq[i].size() < dpv[i] || out_ready);
  endfunction

  function automatic bit m_valid(int i);
    return !flush && mq[i].size() > 0 && (cyc - mq[i][0].t) >= dpv[i];
  endfunction

  function automatic int m_count(int i);
    return mq[i].size();
  endfunction

  function automatic void m_edge();
    for (int i = 0; i < NI; i++) begin
      bit    r, v;
      beat_t b;
      r = m_ready(i);
      v = m_valid(i);
      if (flush) mq[i].delete();
      else begin
        if (v && out_ready) void'(mq[i].pop_front());
        if (in_valid && r) begin
          b.d = din;
          b.t = cyc;
          mq[i].push_back(b);
        end
      end
    end
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < NI; i++) mq[i].delete();
  endfunction

  task automatic tick();
    m_edge();
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din = '0;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din = '0;
    m_reset();
    #1;
    for (int i = 0; i < NI; i++) begin
      checks++; if (ovld[i] !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d]: got %0b want 0", i, ovld[i]); end
      checks++; if (cnt[i] !== 0) begin errors++; $display("FAIL reset_count[%0d]: got %0d want 0", i, cnt[i]); end
      checks++; if (irdy[i] !== 1'b1) begin errors++; $display("FAIL reset_in_ready[%0d]: got %0b want 1", i, irdy[i]); end
      checks++; if (dq[i] !== rstv[i]) begin errors++; $display("FAIL reset_dout[%0d]: got %0h want %0h", i, dq[i], rstv[i]); end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      checks++; if (irdy[i] !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready[%0d]: got %0b want 1", i, irdy[i]); end
    end
  endtask

  task automatic test_stream();
    logic [31:0] seq [3];
    int          exp_ov [6];
    logic [31:0] exp_d  [6];
    int          exp_c  [6];
    seq    = '{32'h11, 32'h22, 32'h33};
    exp_ov = '{0, 0, 1, 1, 1, 0};
    exp_d  = '{32'h0, 32'h0, 32'h11, 32'h22, 32'h33, 32'h0};
    exp_c  = '{0, 1, 2, 2, 1, 0};
    apply_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_valid = (k < 3);
      din      = (k < 3) ? seq[k] : 32'h0;
      #1;
      checks++; if (ovld[0] !== 1'(exp_ov[k])) begin errors++; $display("FAIL stream_out_valid c%0d: got %0b want %0d", k, ovld[0], exp_ov[k]); end
      if (exp_ov[k] == 1) begin
        checks++; if (dq[0] !== exp_d[k]) begin errors++; $display("FAIL stream_dout c%0d: got %0h want %0h", k, dq[0], exp_d[k]); end
      end
      checks++; if (cnt[0] !== exp_c[k]) begin errors++; $display("FAIL stream_count c%0d: got %0d want %0d", k, cnt[0], exp_c[k]); end
      checks++; if (irdy[0] !== 1'b1) begin errors++; $display("FAIL stream_in_ready c%0d: got %0b want 1", k, irdy[0]); end
      tick();
    end
  endtask

  task automatic test_fill();
    int          acc;
    int          first, last;
    logic [31:0] got [$];
    acc = 0;
    apply_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      din = 32'(acc + 1);
      #1;
      checks++; if (irdy[2] !== 1'(k < 4)) begin errors++; $display("FAIL fill_in_ready c%0d: got %0b want %0b", k, irdy[2], (k < 4)); end
      checks++; if (cnt[2] !== ((k < 4) ? k : 4)) begin errors++; $display("FAIL fill_count c%0d: got %0d want %0d", k, cnt[2], (k < 4) ? k : 4); end
      if (k < 4) acc++;
      tick();
    end
    #1;
    checks++; if (ovld[2] !== 1'b1) begin errors++; $display("FAIL full_out_valid: got %0b want 1", ovld[2]); end
    checks++; if (dq[2] !== 32'd1) begin errors++; $display("FAIL full_dout: got %0h want 1", dq[2]); end
    out_ready = 1'b1;
    first = -1; last = -1;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) in_valid = 1'b0;
      #1;
      if (k == 0) begin
        checks++; if (irdy[2] !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %0b want 1", irdy[2]); end
      end
      checks++; if (ovld[2] !== m_valid(2)) begin errors++; $display("FAIL drain_out_valid c%0d: got %0b want %0b", k, ovld[2], m_valid(2)); end
      if (ovld[2] === 1'b1) begin
        got.push_back(dq[2]);
        if (first < 0) first = k;
        last = k;
      end
      tick();
    end
    checks++; if (got.size() !== 5) begin errors++; $display("FAIL drain_beats: got %0d want 5", got.size()); end
    for (int j = 0; j < got.size() && j < 5; j++) begin
      checks++; if (got[j] !== 32'(j + 1)) begin errors++; $display("FAIL drain_order[%0d]: got %0h want %0h", j, got[j], j + 1); end
    end
    checks++; if (last - first !== 4) begin errors++; $display("FAIL drain_gapless: got span %0d want 4", last - first); end
  endtask

  task automatic test_bubble();
    logic [31:0] expd [3];
    expd = '{32'hA1, 32'hA3, 32'hA5};
    apply_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = ((k % 2) == 0);
      din      = 32'hA1 + 32'(k);
      #1;
      checks++; if (irdy[1] !== 1'b1) begin errors++; $display("FAIL bubble_in_ready c%0d: got %0b want 1", k, irdy[1]); end
      tick();
    end
    in_valid = 1'b0;
    #1;
    checks++; if (cnt[1] !== 3) begin errors++; $display("FAIL bubble_count: got %0d want 3", cnt[1]); end
    checks++; if (irdy[1] !== 1'b0) begin errors++; $display("FAIL bubble_full_ready: got %0b want 0", irdy[1]); end
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      #1;
      checks++; if (ovld[1] !== 1'b1) begin errors++; $display("FAIL bubble_out_valid[%0d]: got %0b want 1", j, ovld[1]); end
      checks++; if (dq[1] !== expd[j]) begin errors++; $display("FAIL bubble_dout[%0d]: got %0h want %0h", j, dq[1], expd[j]); end
      tick();
    end
    #1;
    checks++; if (ovld[1] !== 1'b0) begin errors++; $display("FAIL bubble_empty_valid: got %0b want 0", ovld[1]); end
  endtask

  task automatic test_flush();
    apply_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      din = 32'h51 + 32'(k);
      tick();
    end
    flush = 1'b1; din = 32'h77;
    #1;
    checks++; if (irdy[2] !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %0b want 0", irdy[2]); end
    checks++; if (ovld[2] !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %0b want 0", ovld[2]); end
    checks++; if (cnt[2] !== 3) begin errors++; $display("FAIL preflush_count: got %0d want 3", cnt[2]); end
    tick();
    flush = 1'b0; din = 32'h99;
    #1;
    checks++; if (cnt[2] !== 0) begin errors++; $display("FAIL postflush_count: got %0d want 0", cnt[2]); end
    checks++; if (irdy[2] !== 1'b1) begin errors++; $display("FAIL postflush_in_ready: got %0b want 1", irdy[2]); end
    tick();
    in_valid = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      #1;
      checks++; if (ovld[2] !== 1'(j == 4)) begin errors++; $display("FAIL flush_latency_valid +%0d: got %0b want %0b", j, ovld[2], (j == 4)); end
      if (j == 4) begin
        checks++; if (dq[2] !== 32'h99) begin errors++; $display("FAIL flush_next_dout: got %0h want 99", dq[2]); end
      end
      tick();
    end
    in_valid = 1'b1; flush = 1'b1; din = 32'hEE;
    for (int j = 0; j < 3; j++) begin
      #1;
      checks++; if (irdy[2] !== 1'b0) begin errors++; $display("FAIL held_flush_ready c%0d: got %0b want 0", j, irdy[2]); end
      tick();
    end
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (cnt[2] !== 0) begin errors++; $display("FAIL held_flush_count: got %0d want 0", cnt[2]); end
  endtask

  task automatic test_reset_stall();
    apply_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      din = 32'hC0 + 32'(k);
      tick();
    end
    #1;
    checks++; if (cnt[2] !== 4) begin errors++; $display("FAIL stall_count: got %0d want 4", cnt[2]); end
    rst = 1'b1;
    m_reset();
    #1;
    checks++; if (ovld[2] !== 1'b0) begin errors++; $display("FAIL midreset_out_valid: got %0b want 0", ovld[2]); end
    checks++; if (dq[2] !== 32'hDEADBEEF) begin errors++; $display("FAIL midreset_dout: got %0h want deadbeef", dq[2]); end
    checks++; if (cnt[2] !== 0) begin errors++; $display("FAIL midreset_count: got %0d want 0", cnt[2]); end
    checks++; if (irdy[2] !== 1'b1) begin errors++; $display("FAIL midreset_in_ready: got %0b want 1", irdy[2]); end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (irdy[2] !== 1'b1) begin errors++; $display("FAIL after_reset_in_ready: got %0b want 1", irdy[2]); end
    checks++; if (ovld[2] !== 1'b0) begin errors++; $display("FAIL after_reset_out_valid: got %0b want 0", ovld[2]); end
  endtask

  task automatic test_random();
    int  dlv [NI];
    bit  done;
    done = 1'b0;
    for (int i = 0; i < NI; i++) dlv[i] = 0;
    apply_reset();
    for (int n = 0; n < 60000 && !done && errors < 50; n++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      din       = $urandom;
      #1;
      for (int i = 0; i < NI; i++) begin
        checks++; if (irdy[i] !== m_ready(i)) begin errors++; $display("FAIL rnd_in_ready dp%0d c%0d: got %0b want %0b", dpv[i], n, irdy[i], m_ready(i)); end
        checks++; if (ovld[i] !== m_valid(i)) begin errors++; $display("FAIL rnd_out_valid dp%0d c%0d: got %0b want %0b", dpv[i], n, ovld[i], m_valid(i)); end
        checks++; if (cnt[i] !== m_count(i)) begin errors++; $display("FAIL rnd_count dp%0d c%0d: got %0d want %0d", dpv[i], n, cnt[i], m_count(i)); end
        if (m_valid(i)) begin
          checks++; if (dq[i] !== mq[i][0].d) begin errors++; $display("FAIL rnd_dout dp%0d c%0d: got %0h want %0h", dpv[i], n, dq[i], mq[i][0].d); end
          if (out_ready) dlv[i]++;
        end
      end
      done = (dlv[3] >= 10000) && (dlv[4] >= 10000) && (dlv[5] >= 10000);
      tick();
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL rnd_beats: got dp1=%0d dp5=%0d dp16=%0d want 10000 each", dlv[3], dlv[4], dlv[5]);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din = '0;
    test_reset();
    test_stream();
    test_fill();
    test_bubble();
    test_flush();
    test_reset_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
